imem_loader: RTL and testbench

//  Writer side of the instruction path: accepts a framed byte stream (host/UART

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader_byte_packer.sv | 45 ++++
 rtl/imem_loader.sv | 143 ++++++++++++++
 tb/tb_imem_loader.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
// States, checksum and counter widths.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_PAYLOAD,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

  localparam int CHK_W  = 8;
  localparam int CNT_W  = 17;
  localparam int WORD_W = 32;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, imem write and status bundle of the loader.
// master = host side, slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  start;
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_data;
  logic                  cpu_hold;
  logic                  done;
  logic                  error;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_addr,
    input  imem_data, cpu_hold, done, error
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_addr,
    output imem_data, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs bytes MSB-first into 32-bit words.
// word_valid_o pulses the cycle after the 4th byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  output logic              last_o
);
  logic [1:0]        idx_q;
  logic [23:0]       sr_q;
  logic [WORD_W-1:0] word_q;
  logic              vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      sr_q   <= '0;
      word_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (clear_i) begin
        idx_q <= '0;
      end else if (shift_i) begin
        sr_q  <= {sr_q[15:0], byte_i};
        idx_q <= idx_q + 2'd1;
        // word_q holds the last written word
        if (idx_q == 2'd3) begin
          word_q <= {sr_q, byte_i};
          vld_q  <= 1'b1;
        end
      end
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = vld_q;
  assign last_o       = (idx_q == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader into instruction memory.
// Holds the CPU while loading, checks an XOR checksum.
module imem_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic          clock,
  input  logic          reset,
  imem_loader_if.slave  bus
);
  import imem_loader_pkg::*;

  state_e                state_q;
  logic                  in_ready_q;
  logic                  cpu_hold_q;
  logic                  done_q;
  logic                  error_q;
  logic [7:0]            len_hi_q;
  logic [15:0]           len_q;
  logic [CNT_W-1:0]      wcnt_q;
  logic [CHK_W-1:0]      chk_q;
  logic [31:0]           tcnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic              hs;
  logic              clr;
  logic              shift;
  logic              last;
  logic              wvld;
  logic              word_end;
  logic              tmo;
  logic [15:0]       n_rx;
  logic [WORD_W-1:0] word;

  // in_ready is high exactly in the frame-receiving states
  assign hs       = bus.in_valid & in_ready_q;
  assign clr      = bus.start & ~in_ready_q;
  assign shift    = hs && (state_q == S_PAYLOAD);
  assign word_end = shift & last;
  assign n_rx     = {len_hi_q, bus.in_data};
  assign tmo      = (TIMEOUT_CYCLES != 0) && in_ready_q && !hs
                    && (tcnt_q == 32'(TIMEOUT_CYCLES - 1));

  imem_loader_byte_packer u_packer (
    .clk_i        (clock),
    .rst_i        (reset),
    .clear_i      (clr),
    .shift_i      (shift),
    .byte_i       (bus.in_data),
    .word_o       (word),
    .word_valid_o (wvld),
    .last_o       (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      len_hi_q   <= '0;
      len_q      <= '0;
      wcnt_q     <= '0;
      chk_q      <= '0;
      tcnt_q     <= '0;
      addr_q     <= '0;
    end else begin
      tcnt_q <= (hs || !in_ready_q) ? '0 : tcnt_q + 32'd1;
      if (shift) chk_q <= chk_q ^ bus.in_data;
      if (word_end) begin
        addr_q <= wcnt_q[ADDR_WIDTH-1:0];
        wcnt_q <= wcnt_q + 1'b1;
      end
      if (tmo) begin
        state_q    <= S_ERROR;
        error_q    <= 1'b1;
        in_ready_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE, S_ERROR: begin
            if (bus.start) begin
              state_q    <= S_LEN_HI;
              in_ready_q <= 1'b1;
              cpu_hold_q <= 1'b1;
              done_q     <= 1'b0;
              error_q    <= 1'b0;
              chk_q      <= '0;
              wcnt_q     <= '0;
            end
          end
          S_LEN_HI: begin
            if (hs) begin
              len_hi_q <= bus.in_data;
              state_q  <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (hs) begin
              len_q <= n_rx;
              if (n_rx == 16'd0) begin
                state_q <= S_CHECK;
              end else if (32'(n_rx) > (32'd1 << ADDR_WIDTH)) begin
                state_q    <= S_ERROR;
                error_q    <= 1'b1;
                in_ready_q <= 1'b0;
              end else begin
                state_q <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (word_end && (wcnt_q + 1'b1 == CNT_W'(len_q)))
              state_q <= S_CHECK;
          end
          S_CHECK: begin
            if (hs) begin
              in_ready_q <= 1'b0;
              if (bus.in_data == chk_q) begin
                state_q    <= S_DONE;
                done_q     <= 1'b1;
                cpu_hold_q <= 1'b0;
              end else begin
                state_q <= S_ERROR;
                error_q <= 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // a strobe pending while reset is high must not reach imem
  assign bus.in_ready  = in_ready_q;
  assign bus.imem_we   = wvld & ~reset;
  assign bus.imem_addr = addr_q;
  assign bus.imem_data = word;
  assign bus.cpu_hold  = cpu_hold_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized frames checked every cycle against a byte-position model.
// Directed frames pin the model with literal expectations.
module tb_imem_loader;
  localparam int AW = 4;
  localparam int TO = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          a;
    logic [31:0] d;
  } wr_t;

  bit          m_busy, m_hold, m_done, m_err, m_we, cmp_en;
  int          m_pos, m_n, m_idle;
  logic [7:0]  m_x, mb;
  logic [31:0] m_acc, m_data;
  logic [AW-1:0] m_addr;
  wr_t         mw;
  wr_t         wlog[$];

  function automatic void m_fail();
    m_err  = 1'b1;
    m_busy = 1'b0;
  endfunction

  // Reference: outcome derived from the byte position within the frame
  always @(posedge clock) begin
    m_we = 1'b0;
    if (reset) begin
      m_busy = 0; m_hold = 0; m_done = 0; m_err = 0;
      m_addr = '0; m_data = '0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy = 1; m_pos = 0; m_x = 0; m_idle = 0;
        m_done = 0; m_err = 0; m_hold = 1;
      end
    end else if (bus.in_valid) begin
      m_idle = 0;
      mb = bus.in_data;
      if (m_pos == 0) begin
        m_n = int'(mb) << 8;
      end else if (m_pos == 1) begin
        m_n += int'(mb);
        if (m_n > 2**AW) m_fail();
      end else if (m_pos < 2 + 4 * m_n) begin
        m_acc = {m_acc[23:0], mb};
        m_x ^= mb;
        if ((m_pos - 2) % 4 == 3) begin
          m_we   = 1'b1;
          m_addr = AW'((m_pos - 2) / 4);
          m_data = m_acc;
          mw.a = (m_pos - 2) / 4;
          mw.d = m_acc;
          wlog.push_back(mw);
        end
      end else if (mb == m_x) begin
        m_done = 1; m_hold = 0; m_busy = 0;
      end else begin
        m_fail();
      end
      m_pos++;
    end else begin
      m_idle++;
      if (m_idle == TO) m_fail();
    end
    cmp_en = 1'b1;
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("in_ready", bus.in_ready, m_busy);
      check("imem_we", bus.imem_we, m_we && !reset);
      check("imem_addr", bus.imem_addr, m_addr);
      check("imem_data", bus.imem_data, m_data);
      check("cpu_hold", bus.cpu_hold, m_hold);
      check("done", bus.done, m_done);
      check("error", bus.error, m_err);
    end
  end

  bit          rnd_start = 0;
  logic [31:0] words[32];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 0;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    if (rnd_start && m_busy && $urandom_range(0, 7) == 0)
      bus.start = 1'b1;
    for (int k = 0; k < 100 && !acc && m_busy; k++) begin
      @(negedge clock);
      acc = bus.in_ready;
      tick();
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (!acc && m_busy) check("accept_bound", acc, 1);
  endtask

  // chk >= 0: literal checksum byte; -1: correct; -2: corrupted
  task automatic send_frame(input int n, input int chk,
                            input int gmax, input int sidx);
    logic [7:0] x = 0;
    logic [7:0] t;
    logic [7:0] bq[$];
    int gap;
    bq.push_back(8'(n >> 8));
    bq.push_back(8'(n));
    for (int i = 0; i < n && i < 32; i++)
      for (int j = 3; j >= 0; j--) begin
        t = words[i][8*j +: 8];
        bq.push_back(t);
        x ^= t;
      end
    if (chk >= 0) bq.push_back(8'(chk));
    else if (chk == -1) bq.push_back(x);
    else bq.push_back(x ^ 8'($urandom_range(1, 255)));
    pulse_start();
    foreach (bq[i]) begin
      if (!m_busy) break;
      if (i == sidx) pulse_start();
      gap = (rnd_start && $urandom_range(0, 59) == 0)
            ? TO + 2 : $urandom_range(0, gmax);
      send_byte(bq[i], gap);
    end
    repeat (2) tick();
  endtask

  int k5;

  initial begin
    bus.start = 0;
    bus.in_valid = 0;
    bus.in_data = 0;
    repeat (3) tick();
    check("rst_ready", bus.in_ready, 0);
    check("rst_we", bus.imem_we, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_data", bus.imem_data, 0);
    check("rst_hold", bus.cpu_hold, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    reset = 1'b0;
    tick();

    words[0] = 32'h20000005;
    words[1] = 32'h28420001;
    wlog.delete();
    send_frame(2, 8'h4E, 0, -1);
    check("t1_nwr", wlog.size(), 2);
    check("t1_a0", wlog[0].a, 0);
    check("t1_d0", wlog[0].d, 32'h20000005);
    check("t1_a1", wlog[1].a, 1);
    check("t1_d1", wlog[1].d, 32'h28420001);
    check("t1_done", bus.done, 1);
    check("t1_hold", bus.cpu_hold, 0);
    check("t1_err", bus.error, 0);

    wlog.delete();
    send_frame(2, 8'h2F, 1, -1);
    check("t2_nwr", wlog.size(), 2);
    check("t2_err", bus.error, 1);
    check("t2_done", bus.done, 0);
    check("t2_hold", bus.cpu_hold, 1);

    wlog.delete();
    send_frame(0, 8'h00, 0, -1);
    check("t3_done", bus.done, 1);
    send_frame(0, 8'h01, 0, -1);
    check("t3_err", bus.error, 1);
    check("t3_nwr", wlog.size(), 0);

    wlog.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h11, 0);
    check("t4_err", bus.error, 1);
    check("t4_ready", bus.in_ready, 0);
    tick();
    check("t4_nwr", wlog.size(), 0);

    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 0);
    k5 = 0;
    while (k5 < 100 && !bus.error) begin
      tick();
      k5++;
    end
    check("t5_tmo_cycles", k5, 20);
    check("t5_nwr", wlog.size(), 0);
    words[0] = 32'hDEADBEEF;
    send_frame(1, -1, 0, -1);
    check("t5_done", bus.done, 1);

    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    reset = 1'b1;
    #1;
    check("t6_we_supp", bus.imem_we, 0);
    tick();
    reset = 1'b0;
    check("t6_ready", bus.in_ready, 0);
    check("t6_addr", bus.imem_addr, 0);
    check("t6_data", bus.imem_data, 0);
    check("t6_hold", bus.cpu_hold, 0);
    check("t6_done", bus.done, 0);
    check("t6_err", bus.error, 0);
    tick();

    wlog.delete();
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    send_frame(3, -1, 0, 7);
    check("t7_nwr", wlog.size(), 3);
    for (int i = 0; i < 3 && i < wlog.size(); i++)
      check("t7_addr", wlog[i].a, i);
    check("t7_done", bus.done, 1);

    rnd_start = 1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 32; i++) words[i] = $urandom;
      send_frame($urandom_range(0, 18),
                 ($urandom_range(0, 6) == 0) ? -2 : -1,
                 $urandom_range(0, 2), -1);
      for (int k = 0; k < 60 && m_busy; k++) tick();
      if (m_busy) check("frame_end_bound", m_busy, 0);
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        repeat (3) tick();
        bus.in_valid = 1'b0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
